ft2232_tx_arbiter: RTL
======================

FT2232_TX_ARBITER -- requirements
Module: ft2232_tx_arbiter

Interface
REQ-001 The block SHALL have parameter HDR0, default 8'hA0: header byte sent before each source-0 packet.
REQ-002 The block SHALL have parameter HDR1, default 8'hA1: header byte sent before each source-1 packet.
REQ-003 The block SHALL have parameter TIMEOUT, default 255: maximum idle cycles inside a packet before abort.
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port src0_data_i, input, 8 bits: source-0 byte.
REQ-007 The block SHALL have port src0_req_i, input, 1 bit: source-0 byte valid.
REQ-008 The block SHALL have port src0_last_i, input, 1 bit: current source-0 byte ends its packet.
REQ-009 The block SHALL have port src0_ack_o, output, 1 bit: source-0 byte consumed.
REQ-010 The block SHALL have ports src1_data_i, src1_req_i, src1_last_i and src1_ack_o, identical in direction and width to REQ-006 to REQ-009, for source 1.
REQ-011 The block SHALL have port out_data_o, output, 8 bits: byte to the FT2232 transmit path.
REQ-012 The block SHALL have port out_req_o, output, 1 bit: out_data_o valid.
REQ-013 The block SHALL have port out_ack_i, input, 1 bit: one-cycle pulse; byte taken by the FT2232 path.
REQ-014 The block SHALL have port grant_o, output, 2 bits: one-hot current owner, 00 when idle.
REQ-015 The block SHALL have port abort_o, output, 1 bit: one-cycle pulse on packet timeout.
REQ-016 The block SHALL have port pkt_count_o, output, 16 bits: count of completed packets.

Function
REQ-017 The block SHALL implement a state machine with states IDLE, HEADER and DATA, plus a 1-bit last_grant register.
REQ-018 In IDLE, with no src*_req_i high, the block SHALL hold out_req_o=0, grant_o=00 and all src*_ack_o=0.
REQ-019 In IDLE, with exactly one src*_req_i high, the block SHALL register that source in grant_o and move to HEADER on the next edge.
REQ-020 In IDLE, with both src*_req_i high, the block SHALL grant the source not equal to last_grant (round-robin).
REQ-021 In HEADER, the block SHALL drive out_req_o=1 and out_data_o=HDR0 or HDR1 per grant, with no src*_ack_o.
REQ-022 In HEADER, on out_ack_i=1 the block SHALL move to DATA.
REQ-023 In DATA, out_req_o SHALL equal the granted src_req_i combinationally, and out_data_o SHALL equal the granted src_data_i combinationally.
REQ-024 In DATA, the granted src_ack_o SHALL equal out_ack_i combinationally, and the other src_ack_o SHALL stay 0.
REQ-025 In DATA, on out_ack_i=1 with granted src_last_i=1, the block SHALL: go to IDLE; set last_grant to the granted source; increment pkt_count_o (16-bit, wraps FFFF to 0000).
REQ-026 After a packet ends, the block SHALL not re-grant on the same edge; at least one IDLE cycle is required between packets.
REQ-027 In DATA, the block SHALL keep an idle counter: cleared on entry to DATA and on any cycle the granted src_req_i=1; incremented otherwise.
REQ-028 When the idle counter reaches TIMEOUT, the block SHALL: go to IDLE; pulse abort_o for one cycle; set last_grant to the granted source; leave pkt_count_o unchanged.
REQ-029 If out_ack_i and the timeout condition coincide, the ack SHALL win and the timeout SHALL be ignored that cycle.
REQ-030 In HEADER, the block SHALL have no timeout; it waits indefinitely for out_ack_i.
REQ-031 A non-granted source's request SHALL never affect out_* outputs or ack lines.
REQ-032 In IDLE and HEADER, out_ack_i SHALL never be forwarded to any src*_ack_o.

Reset
REQ-033 When reset_i=1 at a clock edge, the block SHALL set: state=IDLE; last_grant=1 (so source 0 wins the first tie); grant_o=00; pkt_count_o=0; idle counter=0.
REQ-034 The registered outputs abort_o and grant_o SHALL be 0 after reset; the combinational outputs out_req_o, out_data_o and src*_ack_o SHALL evaluate to 0 given the reset state.
REQ-035 A reset asserted mid-packet SHALL drop the packet immediately, with no abort_o pulse and no count increment.

Verification
REQ-036 The bench SHALL cover: src0 3-byte packet 11,22,33 (last on 33), out_ack_i every 4th cycle -> out bytes A0,11,22,33; src0_ack_o 3 pulses; pkt_count_o=1.
REQ-037 The bench SHALL cover: both sources requesting from reset -> order A0,src0 packet,A1,src1 packet; then both again -> src0 granted (last_grant=1).
REQ-038 The bench SHALL cover: src1 deasserts req mid-packet for TIMEOUT cycles -> abort_o one pulse; return to IDLE; pkt_count_o unchanged; src0 then granted.
REQ-039 The bench SHALL cover: src1 req rises while the src0 packet is in DATA -> no src1_ack_o and no interleaving; src1 header follows only after the src0 last byte.
REQ-040 The bench SHALL cover: reset_i pulsed during a DATA byte -> next cycle out_req_o=0, grant_o=00, pkt_count_o=0.
REQ-041 The bench SHALL cover: pkt_count_o preloaded to FFFF by running 65535 packets (or a forced start) -> next completed packet gives 0000.

Source files
------------

// File: rtl/ft2232_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ft2232_tx_arbiter
// Brief   : Round-robin packet arbiter merging two byte sources onto the FT2232 TX path.
// Rev     : 1.0
// ============================================================================
module ft2232_tx_arbiter #(
    parameter logic [7:0] HDR0    = 8'hA0,
    parameter logic [7:0] HDR1    = 8'hA1,
    parameter int         TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  src0_data_i,
    input  logic        src0_req_i,
    input  logic        src0_last_i,
    output logic        src0_ack_o,
    input  logic [7:0]  src1_data_i,
    input  logic        src1_req_i,
    input  logic        src1_last_i,
    output logic        src1_ack_o,
    output logic [7:0]  out_data_o,
    output logic        out_req_o,
    input  logic        out_ack_i,
    output logic [1:0]  grant_o,
    output logic        abort_o,
    output logic [15:0] pkt_count_o
);

    localparam int            c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LIMIT = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [c_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [15:0]          pkt_count_q, pkt_count_d;
    logic                 abort_q, abort_d;

    logic                 sel_req;
    logic                 sel_last;
    logic [7:0]           sel_data;

    assign sel_req  = grant_q[1] ? src1_req_i  : src0_req_i;
    assign sel_last = grant_q[1] ? src1_last_i : src0_last_i;
    assign sel_data = grant_q[1] ? src1_data_i : src0_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            idle_cnt_q   <= '0;
            pkt_count_q  <= 16'h0000;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            idle_cnt_q   <= idle_cnt_d;
            pkt_count_q  <= pkt_count_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        idle_cnt_d   = idle_cnt_q;
        pkt_count_d  = pkt_count_q;
        abort_d      = 1'b0;
        out_req_o    = 1'b0;
        out_data_o   = 8'h00;
        src0_ack_o   = 1'b0;
        src1_ack_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                idle_cnt_d = '0;
                // On a tie, the source that did not own the previous packet wins.
                if (src0_req_i && src1_req_i) begin
                    grant_d = last_grant_q ? 2'b01 : 2'b10;
                    state_d = S_HEADER;
                end else if (src0_req_i) begin
                    grant_d = 2'b01;
                    state_d = S_HEADER;
                end else if (src1_req_i) begin
                    grant_d = 2'b10;
                    state_d = S_HEADER;
                end
            end

            S_HEADER: begin
                out_req_o  = 1'b1;
                out_data_o = grant_q[1] ? HDR1 : HDR0;
                if (out_ack_i) begin
                    state_d    = S_DATA;
                    idle_cnt_d = '0;
                end
            end

            S_DATA: begin
                out_req_o  = sel_req;
                out_data_o = sel_data;
                src0_ack_o = out_ack_i & grant_q[0];
                src1_ack_o = out_ack_i & grant_q[1];
                if (out_ack_i && sel_last) begin
                    state_d      = S_IDLE;
                    grant_d      = 2'b00;
                    last_grant_d = grant_q[1];
                    pkt_count_d  = pkt_count_q + 16'd1;
                    idle_cnt_d   = '0;
                end else if (!out_ack_i && !sel_req && (idle_cnt_q >= c_TO_LIMIT)) begin
                    // This idle cycle is the TIMEOUT-th in a row: drop the packet.
                    state_d      = S_IDLE;
                    grant_d      = 2'b00;
                    last_grant_d = grant_q[1];
                    abort_d      = 1'b1;
                    idle_cnt_d   = '0;
                end else if (sel_req) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign grant_o     = grant_q;
    assign abort_o     = abort_q;
    assign pkt_count_o = pkt_count_q;

endmodule
`default_nettype wire
